// File: rtl/usb20sr_refdes_cpu_qsys_gen2_cpu_oci_dct_packer_if.sv
// Atom input and frame output handshake bundle for the DCT trace packer.
// slave = packer side, master = atom producer / frame consumer side.
interface usb20sr_refdes_cpu_qsys_gen2_cpu_oci_dct_packer_if;
  logic        atom_valid;
  logic [1:0]  atom;
  logic        atom_ready;
  logic        flush;
  logic        dct_valid;
  logic        dct_ready;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;

  modport slave (
    input  atom_valid, atom, flush, dct_ready,
    output atom_ready, dct_valid, dct_buffer, dct_count
  );

  modport master (
    output atom_valid, atom, flush, dct_ready,
    input  atom_ready, dct_valid, dct_buffer, dct_count
  );
endinterface

// File: rtl/usb20sr_refdes_cpu_qsys_gen2_cpu_oci_dct_packer.sv
// Packs 2-bit DCT trace atoms into 30-bit frames, closed when full or on flush,
// behind a one-entry valid/ready output register.
//
// state   | meaning
// EMPTY   | no atoms held, flush ignored
// FILL    | 1..14 atoms held, accepting
// FULL    | 15 atoms held, waiting for output slot
// DRAIN   | flushed partial frame, waiting for output slot
module usb20sr_refdes_cpu_qsys_gen2_cpu_oci_dct_packer #(
  parameter int ATOM_W    = 2,
  parameter int MAX_ATOMS = 15,
  parameter int CNT_W     = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  usb20sr_refdes_cpu_qsys_gen2_cpu_oci_dct_packer_if.slave bus,
  output logic [15:0] frame_count_o,
  output logic        illegal_atom_o
);
  localparam int FRAME_W = ATOM_W * MAX_ATOMS;

  typedef enum logic [1:0] {S_EMPTY, S_FILL, S_FULL, S_DRAIN} state_e;

  state_e               state_q, state_d;
  logic [FRAME_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     acc_cnt_q, acc_cnt_d;
  logic                 atom_ready_q, atom_ready_d;
  logic                 dct_valid_q;
  logic [FRAME_W-1:0]   dct_buffer_q;
  logic [CNT_W-1:0]     dct_count_q;
  logic [15:0]          frame_count_q;
  logic                 illegal_q;

  logic accept, drop, slot_free, load;

  always_comb begin
    accept    = bus.atom_valid & atom_ready_q & (bus.atom != '0);
    drop      = bus.atom_valid & atom_ready_q & (bus.atom == '0);
    slot_free = ~dct_valid_q | bus.dct_ready;
    load      = ((state_q == S_FULL) || (state_q == S_DRAIN)) & slot_free;

    state_d   = state_q;
    acc_d     = acc_q;
    acc_cnt_d = acc_cnt_q;

    case (state_q)
      S_EMPTY, S_FILL: begin
        if (accept) begin
          acc_d[ATOM_W*int'(acc_cnt_q) +: ATOM_W] = bus.atom;
          acc_cnt_d = acc_cnt_q + CNT_W'(1);
        end
        if (acc_cnt_d == CNT_W'(MAX_ATOMS))
          state_d = S_FULL;
        // A flush needs at least one atom held before this edge; an atom
        // accepted alongside the flush still lands in the closing frame.
        else if (state_q == S_FILL && bus.flush)
          state_d = S_DRAIN;
        else if (acc_cnt_d != '0)
          state_d = S_FILL;
      end
      S_FULL, S_DRAIN: begin
        if (slot_free) begin
          acc_d     = '0;
          acc_cnt_d = '0;
          state_d   = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase

    atom_ready_d = (acc_cnt_d != CNT_W'(MAX_ATOMS)) & (state_d != S_DRAIN);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= S_EMPTY;
      acc_q         <= '0;
      acc_cnt_q     <= '0;
      atom_ready_q  <= 1'b1;
      dct_valid_q   <= 1'b0;
      dct_buffer_q  <= '0;
      dct_count_q   <= '0;
      frame_count_q <= '0;
      illegal_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      acc_cnt_q    <= acc_cnt_d;
      atom_ready_q <= atom_ready_d;
      // A new frame loading wins over the consumer draining the slot.
      if (load) begin
        dct_valid_q   <= 1'b1;
        dct_buffer_q  <= acc_q;
        dct_count_q   <= acc_cnt_q;
        frame_count_q <= frame_count_q + 16'd1;
      end else if (dct_valid_q & bus.dct_ready) begin
        dct_valid_q <= 1'b0;
      end
      if (drop)
        illegal_q <= 1'b1;
    end
  end

  assign bus.atom_ready = atom_ready_q;
  assign bus.dct_valid  = dct_valid_q;
  assign bus.dct_buffer = dct_buffer_q;
  assign bus.dct_count  = dct_count_q;
  assign frame_count_o  = frame_count_q;
  assign illegal_atom_o = illegal_q;
endmodule

// File: tb/tb_usb20sr_refdes_cpu_qsys_gen2_cpu_oci_dct_packer.sv
// Directed vector table plus hand sequences for the DCT trace packer.
module tb_usb20sr_refdes_cpu_qsys_gen2_cpu_oci_dct_packer;
  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [15:0] frame_count_o;
  logic        illegal_atom_o;
  int          total = 0;
  int          bad   = 0;

  usb20sr_refdes_cpu_qsys_gen2_cpu_oci_dct_packer_if bus();

  usb20sr_refdes_cpu_qsys_gen2_cpu_oci_dct_packer dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .bus            (bus.slave),
    .frame_count_o  (frame_count_o),
    .illegal_atom_o (illegal_atom_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        v;
    logic [1:0]  a;
    logic        fl;
    logic        dr;
    logic        rdy;
    logic        dv;
    logic [29:0] bf;
    logic [3:0]  cnt;
    logic [15:0] fc;
    logic        ill;
  } vec_t;

  vec_t tbl[18];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    bus.atom_valid = 1'b0;
    bus.atom = 2'b00;
    bus.flush = 1'b0;
    bus.dct_ready = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic rdy, input logic dv,
                         input logic [29:0] bf, input logic [3:0] cnt,
                         input logic [15:0] fc, input logic ill);
    chk({tag, ".rdy"}, 32'(bus.atom_ready), 32'(rdy));
    chk({tag, ".dv"},  32'(bus.dct_valid),  32'(dv));
    chk({tag, ".buf"}, 32'(bus.dct_buffer), 32'(bf));
    chk({tag, ".cnt"}, 32'(bus.dct_count),  32'(cnt));
    chk({tag, ".fc"},  32'(frame_count_o),  32'(fc));
    chk({tag, ".ill"}, 32'(illegal_atom_o), 32'(ill));
  endtask

  initial begin
    logic [29:0] exp_f[2];
    logic [1:0]  a;
    logic        r;
    logic        hold_ok;
    logic        ready_ok;
    int          sent;
    int          cyc;
    int          loaded;

    //          v  a      fl dr  rdy dv buf          cnt fc ill
    tbl[0]  = '{1, 2'b01, 0, 1,  1,  0, 30'h0,       0,  0, 0};
    tbl[1]  = '{1, 2'b10, 0, 1,  1,  0, 30'h0,       0,  0, 0};
    tbl[2]  = '{1, 2'b11, 0, 1,  1,  0, 30'h0,       0,  0, 0};
    tbl[3]  = '{0, 2'b00, 1, 1,  0,  0, 30'h0,       0,  0, 0};
    tbl[4]  = '{0, 2'b00, 0, 0,  1,  1, 30'h39,      3,  1, 0};
    tbl[5]  = '{0, 2'b00, 0, 0,  1,  1, 30'h39,      3,  1, 0};
    tbl[6]  = '{0, 2'b00, 1, 1,  1,  0, 30'h39,      3,  1, 0};
    tbl[7]  = '{0, 2'b00, 0, 1,  1,  0, 30'h39,      3,  1, 0};
    tbl[8]  = '{1, 2'b00, 0, 1,  1,  0, 30'h39,      3,  1, 1};
    tbl[9]  = '{1, 2'b01, 0, 1,  1,  0, 30'h39,      3,  1, 1};
    tbl[10] = '{0, 2'b00, 1, 1,  0,  0, 30'h39,      3,  1, 1};
    tbl[11] = '{0, 2'b00, 0, 1,  1,  1, 30'h1,       1,  2, 1};
    tbl[12] = '{1, 2'b10, 0, 1,  1,  0, 30'h1,       1,  2, 1};
    tbl[13] = '{1, 2'b10, 0, 1,  1,  0, 30'h1,       1,  2, 1};
    tbl[14] = '{1, 2'b10, 0, 1,  1,  0, 30'h1,       1,  2, 1};
    tbl[15] = '{1, 2'b11, 1, 1,  0,  0, 30'h1,       1,  2, 1};
    tbl[16] = '{0, 2'b00, 0, 1,  1,  1, 30'hEA,      4,  3, 1};
    tbl[17] = '{0, 2'b00, 0, 1,  1,  0, 30'hEA,      4,  3, 1};

    do_reset();
    chk_out("reset", 1'b1, 1'b0, 30'h0, 4'd0, 16'd0, 1'b0);

    for (int i = 0; i < 18; i++) begin
      bus.atom_valid = tbl[i].v;
      bus.atom       = tbl[i].a;
      bus.flush      = tbl[i].fl;
      bus.dct_ready  = tbl[i].dr;
      tick();
      chk_out($sformatf("row%0d", i), tbl[i].rdy, tbl[i].dv, tbl[i].bf,
              tbl[i].cnt, tbl[i].fc, tbl[i].ill);
    end
    bus.atom_valid = 1'b0;
    bus.flush = 1'b0;

    // 15 taken atoms, consumer always ready
    do_reset();
    ready_ok = 1'b1;
    for (int i = 0; i < 15; i++) begin
      bus.atom_valid = 1'b1;
      bus.atom = 2'b10;
      tick();
      if (i < 14 && bus.atom_ready !== 1'b1) ready_ok = 1'b0;
    end
    chk("full.ready_high_before_15", 32'(ready_ok), 32'd1);
    chk("full.bubble_ready", 32'(bus.atom_ready), 32'd0);
    chk("full.dv_not_yet", 32'(bus.dct_valid), 32'd0);
    bus.atom_valid = 1'b0;
    tick();
    chk_out("full.out", 1'b1, 1'b1, 30'h2AAAAAAA, 4'd15, 16'd1, 1'b0);

    // 30 atoms against a stalled consumer, then release
    do_reset();
    bus.dct_ready = 1'b0;
    exp_f[0] = '0;
    exp_f[1] = '0;
    for (int i = 0; i < 30; i++) begin
      a = 2'(((i / 2) % 3) + 1);
      exp_f[i / 15][2*(i % 15) +: 2] = a;
    end
    sent = 0;
    cyc = 0;
    hold_ok = 1'b1;
    loaded = 0;
    while (sent < 30 && cyc < 80) begin
      a = 2'(((sent / 2) % 3) + 1);
      bus.atom_valid = 1'b1;
      bus.atom = a;
      r = bus.atom_ready;
      tick();
      cyc++;
      if (r) sent++;
      if (bus.dct_valid) begin
        if (loaded == 0) loaded = 1;
        if (bus.dct_buffer !== exp_f[0] || bus.dct_count !== 4'd15) hold_ok = 1'b0;
      end
    end
    chk("bp.sent_in_budget", 32'(sent), 32'd30);
    bus.atom_valid = 1'b0;
    tick();
    tick();
    chk("bp.hold_stable", 32'(hold_ok), 32'd1);
    chk("bp.first_seen", 32'(loaded), 32'd1);
    chk_out("bp.stalled", 1'b0, 1'b1, exp_f[0], 4'd15, 16'd1, 1'b0);
    bus.dct_ready = 1'b1;
    tick();
    chk_out("bp.second", 1'b1, 1'b1, exp_f[1], 4'd15, 16'd2, 1'b0);
    tick();
    chk("bp.drained_dv", 32'(bus.dct_valid), 32'd0);

    // reset mid-frame with a held frame and sticky error
    do_reset();
    bus.dct_ready = 1'b0;
    bus.atom_valid = 1'b1;
    bus.atom = 2'b00;
    tick();
    bus.atom = 2'b01;
    tick();
    bus.atom_valid = 1'b0;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) begin
      bus.atom_valid = 1'b1;
      bus.atom = 2'b10;
      tick();
    end
    bus.atom_valid = 1'b0;
    chk("rst.pre_dv", 32'(bus.dct_valid), 32'd1);
    chk("rst.pre_ill", 32'(illegal_atom_o), 32'd1);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    chk_out("rst.post", 1'b1, 1'b0, 30'h0, 4'd0, 16'd0, 1'b0);
    bus.dct_ready = 1'b1;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    tick();
    chk("rst.acc_discarded", 32'(bus.dct_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
